// File: rtl/b2xs3_pkg.sv
// Shared types and constants for the BCD-to-excess-3 converter.
package b2xs3_pkg;

   typedef logic [3:0] nibble_t;

   localparam nibble_t XS3_OFFSET = 4'd3;
   localparam nibble_t BCD_MAX    = 4'd9;

   // Result of converting one digit: wrapped excess-3 code plus range flag
   typedef struct packed {
      nibble_t xs3;
      logic    err;
   } digit_res_t;

   // Excess-3 of one nibble, wrapping mod 16; err marks non-BCD input
   function automatic digit_res_t conv_digit(input nibble_t d);
      digit_res_t r;
      r.xs3 = d + XS3_OFFSET;
      r.err = (d > BCD_MAX);
      return r;
   endfunction

endpackage

// File: rtl/b2xs3_digit.sv
// Combinational single-digit BCD to excess-3 converter with range flag.
module b2xs3_digit
   import b2xs3_pkg::*;
(
   input  nibble_t bcd,
   output nibble_t xs3,
   output logic    err
);

   digit_res_t res;

   // Convert one digit; invalid digits still yield the wrapped sum
   always_comb begin
      res = conv_digit(bcd);
      xs3 = res.xs3;
      err = res.err;
   end

endmodule

// File: rtl/b2xs3.sv
// Registered BCD to excess-3 converter for DIGITS parallel digits.
// Optional sticky error flag with clear input: define B2XS3_STICKY_ERR_EN.
module b2xs3
   import b2xs3_pkg::*;
#(
   parameter int unsigned DIGITS = 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [4*DIGITS-1:0] bin,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] xs3,
   output logic                invalid,
   output logic [DIGITS-1:0]   digit_err
`ifdef B2XS3_STICKY_ERR_EN
   ,
   input  logic                err_clr,
   output logic                err_sticky
`endif
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0]      xs3_c;
   logic [DIGITS-1:0] err_c;
   logic              invalid_c;

   logic              out_valid_d, out_valid_q;
   logic [W-1:0]      xs3_d, xs3_q;
   logic              invalid_d, invalid_q;
   logic [DIGITS-1:0] digit_err_d, digit_err_q;

   // One converter per digit; digits are independent, no carry between them
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      b2xs3_digit u_digit (
         .bcd (bin[4*k +: 4]),
         .xs3 (xs3_c[4*k +: 4]),
         .err (err_c[k])
      );
   end

   // Any out-of-range digit makes the whole word invalid
   always_comb begin
      invalid_c = |err_c;
   end

   // Capture a new result on valid input, otherwise hold the data outputs
   always_comb begin
      out_valid_d = in_valid;
      xs3_d       = xs3_q;
      invalid_d   = invalid_q;
      digit_err_d = digit_err_q;
      if (in_valid) begin
         xs3_d       = xs3_c;
         invalid_d   = invalid_c;
         digit_err_d = err_c;
      end
   end

   // Output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         xs3_q       <= '0;
         invalid_q   <= 1'b0;
         digit_err_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         xs3_q       <= xs3_d;
         invalid_q   <= invalid_d;
         digit_err_q <= digit_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign xs3       = xs3_q;
   assign invalid   = invalid_q;
   assign digit_err = digit_err_q;

`ifdef B2XS3_STICKY_ERR_EN
   logic err_sticky_d, err_sticky_q;

   // Sticky error: a new error wins over a simultaneous clear
   always_comb begin
      err_sticky_d = err_sticky_q;
      if (in_valid && invalid_c) begin
         err_sticky_d = 1'b1;
      end else if (err_clr) begin
         err_sticky_d = 1'b0;
      end
   end

   // Sticky flag register, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky_q <= 1'b0;
      end else begin
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_b2xs3.sv
// Scoreboard bench for b2xs3: one DIGITS=1 and one DIGITS=2 instance share stimulus.
module tb_b2xs3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] bin = '0;
   logic       err_clr = 1'b0;

   logic       ov1, inv1;
   logic [3:0] x1;
   logic [0:0] de1;
   logic       ov2, inv2;
   logic [7:0] x2;
   logic [1:0] de2;
   logic       sticky1, sticky2;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b1;

   always #5 clk = ~clk;

   b2xs3 #(.DIGITS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bin(bin[3:0]),
      .out_valid(ov1), .xs3(x1), .invalid(inv1), .digit_err(de1)
`ifdef B2XS3_STICKY_ERR_EN
      , .err_clr(err_clr), .err_sticky(sticky1)
`endif
   );

   b2xs3 #(.DIGITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bin(bin),
      .out_valid(ov2), .xs3(x2), .invalid(inv2), .digit_err(de2)
`ifdef B2XS3_STICKY_ERR_EN
      , .err_clr(err_clr), .err_sticky(sticky2)
`endif
   );

`ifndef B2XS3_STICKY_ERR_EN
   assign sticky1 = 1'b0;
   assign sticky2 = 1'b0;
`endif

   // Expected outputs for one accepted word, for both instances
   typedef struct {
      logic [7:0] x2;
      logic [1:0] de2;
      logic       inv2;
      logic [3:0] x1;
      logic       de1;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   bit   exp_ov = 1'b0;
   bit   st1 = 1'b0, st2 = 1'b0;

   // Reference: each digit is value+3 modulo 16, error when value exceeds 9
   function automatic exp_t model(input logic [7:0] b);
      exp_t e;
      int   d;
      e.x2 = '0;
      e.de2 = '0;
      for (int k = 0; k < 2; k++) begin
         d = (b >> (4 * k)) & 15;
         e.x2 = e.x2 | 8'(((d + 3) % 16) << (4 * k));
         e.de2[k] = (d > 9);
      end
      e.inv2 = (e.de2 != 2'b00);
      e.x1   = e.x2[3:0];
      e.de1  = e.de2[0];
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then advance the reference state at the edge
   task automatic step(input bit v, input logic [7:0] b, input bit clr, input bit r);
      exp_t e;
      rst_n    = r;
      in_valid = v;
      bin      = b;
      err_clr  = clr;
      @(posedge clk);
      if (!r) begin
         exp_ov = 1'b0;
         last_e = '{x2: 8'h00, de2: 2'b00, inv2: 1'b0, x1: 4'h0, de1: 1'b0};
         st1 = 1'b0;
         st2 = 1'b0;
      end else if (v) begin
         e = model(b);
         sb.push_back(e);
         last_e = e;
         exp_ov = 1'b1;
         if (e.de1) st1 = 1'b1; else if (clr) st1 = 1'b0;
         if (e.inv2) st2 = 1'b1; else if (clr) st2 = 1'b0;
      end else begin
         exp_ov = 1'b0;
         if (clr) begin
            st1 = 1'b0;
            st2 = 1'b0;
         end
      end
      #1;
   endtask

   // Monitor: pop and compare whenever the DUT presents a result
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("out_valid1", 32'(ov1), 32'(exp_ov));
         chk("out_valid2", 32'(ov2), 32'(exp_ov));
         if (ov2 === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("xs3_1", 32'(x1), 32'(e.x1));
               chk("derr_1", 32'(de1), 32'(e.de1));
               chk("inv_1", 32'(inv1), 32'(e.de1));
               chk("xs3_2", 32'(x2), 32'(e.x2));
               chk("derr_2", 32'(de2), 32'(e.de2));
               chk("inv_2", 32'(inv2), 32'(e.inv2));
            end
         end else begin
            chk("hold_xs3_1", 32'(x1), 32'(last_e.x1));
            chk("hold_inv_1", 32'(inv1), 32'(last_e.de1));
            chk("hold_xs3_2", 32'(x2), 32'(last_e.x2));
            chk("hold_derr_2", 32'(de2), 32'(last_e.de2));
            chk("hold_inv_2", 32'(inv2), 32'(last_e.inv2));
         end
`ifdef B2XS3_STICKY_ERR_EN
         chk("sticky1", 32'(sticky1), 32'(st1));
         chk("sticky2", 32'(sticky2), 32'(st2));
`endif
      end
   end

   initial begin
      last_e = '{x2: 8'h00, de2: 2'b00, inv2: 1'b0, x1: 4'h0, de1: 1'b0};

      // Reset with valid input present: must be ignored
      step(1'b1, 8'h05, 1'b0, 1'b0);
      step(1'b1, 8'h05, 1'b0, 1'b0);

      // Full nibble sweep on consecutive cycles
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);

      // Hold: valid 7 then idle with different data
      step(1'b1, 8'h07, 1'b0, 1'b1);
      step(1'b0, 8'h02, 1'b0, 1'b1);
      step(1'b0, 8'h02, 1'b0, 1'b1);

      // Multi-digit words
      step(1'b1, 8'h93, 1'b0, 1'b1);
      step(1'b1, 8'h4B, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Sticky flag sequence: set, keep, clear, set-wins-over-clear
      step(1'b1, 8'h0C, 1'b0, 1'b1);
      step(1'b1, 8'h02, 1'b0, 1'b1);
      step(1'b0, 8'h02, 1'b1, 1'b1);
      step(1'b0, 8'h02, 1'b0, 1'b1);
      step(1'b1, 8'h0F, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Back-to-back 9,0,9
      step(1'b1, 8'h09, 1'b0, 1'b1);
      step(1'b1, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h09, 1'b0, 1'b1);

      // Reset mid-stream discards the transfer in flight
      step(1'b1, 8'hAB, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Randomized traffic with occasional reset and clear
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 49) != 0));
      end

      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
